tlc_frame_scheduler: RTL and testbench
======================================

Name: tlc_frame_scheduler

Overview:
Sequences the LED driver chain for one display panel. It owns BLANK, XLAT, MODE and GSCLK timing, and it issues shift requests to the serial shifter. At startup it runs a one-time dot-correction (DC) upload, then runs continuous grayscale (GS) PWM cycles. New GS data is latched only inside the blank window. It sits between the frame source and the pixel shift engine, in place of ad-hoc timing inside the pixel driver.

Parameters:
GS_BITS, 12, PWM resolution; one GS cycle = 2^GS_BITS GSCLK rising edges.
BLANK_CYCLES, 4, clocks that led_blank stays high between GS cycles (min 3).
DC_ON_START, 1, 1 = perform DC upload after reset; 0 = go straight to GS operation.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = run the scheduler; 0 = finish current GS cycle, then hold blank
frame_req  in  1  one-clock pulse: new GS frame available in the source buffer
shift_start  out  1  one-clock pulse: shifter begins loading the chain
shift_dc  out  1  qualifies shift_start: 1 = DC data, 0 = GS data; held stable while shifter busy
shift_done  in  1  one-clock pulse from shifter: last bit shifted
led_mode  out  1  driver MODE pin; 1 = DC register selected
led_blank  out  1  driver BLANK pin
led_xlat  out  1  driver XLAT pin
led_gsclk  out  1  driver GSCLK pin
led_xerr  in  1  driver XERR, active-low, asynchronous to clock
frame_tick  out  1  one-clock pulse at each BLANK entry
frame_count  out  16  GS cycles completed, wraps at 0xFFFF→0

Behaviour:
- Reset values:
  - led_blank=1, led_mode=0, led_xlat=0, led_gsclk=0, shift_start=0, shift_dc=0, frame_tick=0, frame_count=0.
  - FSM in IDLE; gs_count=0; pending=0; busy=0.
- States:
  - IDLE: blank=1. If enable=1 and DC_ON_START=1, go to DC_SHIFT; if enable=1 and DC_ON_START=0, go to BLANK.
  - DC_SHIFT: led_mode=1, shift_dc=1, one-clock shift_start on entry. Wait for shift_done, then go to DC_LATCH.
  - DC_LATCH: led_xlat=1 for exactly 1 clock. Next clock led_mode=0, go to BLANK.
  - RUN:
    - blank=0; led_gsclk toggles every clock, so the GSCLK period is 2 clocks.
    - gs_count increments on each low→high transition of led_gsclk.
    - When gs_count reaches 2^GS_BITS, force gsclk=0, reset gs_count=0, go to BLANK.
    - Total RUN length is 2^(GS_BITS+1) clocks.
  - BLANK:
    - blank=1 for BLANK_CYCLES clocks; gsclk=0; frame_tick pulses on the entry clock.
    - frame_count increments on entry, except on the first entry after IDLE.
    - If pending=1 at blank clock 1: xlat=1 for exactly that one clock (clock index 1, 0-based), then pending is cleared.
    - On exit: if enable=1, go to RUN; otherwise go to IDLE.
- GS shift handshake (concurrent with RUN/BLANK):
  - busy is set by shift_start and cleared by shift_done.
  - A frame_req arriving while busy=0 and the FSM is not in DC states produces shift_start (shift_dc=0) on the next clock.
  - A frame_req arriving while busy=1, or during DC states, is remembered in a 1-deep req_q. It is issued on the clock after busy clears or after DC completes. Further requests overwrite req_q (coalesce).
  - shift_done with shift_dc=0 sets pending. If pending is already 1 and unlatched, it stays 1; the newer data overwrites the older.
  - shift_done and the xlat clock coinciding: xlat is issued for the current pending, and pending stays 1 for the next blank.
  - shift_start is never issued on the xlat clock; it is deferred 1 clock.
- Enable deasserted mid-RUN: the GS cycle completes normally. Mid-DC: the DC upload completes, then the FSM goes to IDLE via BLANK.
- reset_n asserted at any point: all outputs immediately return to reset values, and the shifter handshake state is discarded.

Optional Feature:
Macro: LED_XERR_MONITOR_EN.
- Defined:
  - led_xerr passes through a 2-flop synchroniser and is sampled only in RUN, at gs_count≥2. Sampling in BLANK is ignored, since XERR is invalid while blanked.
  - Adds output xerr_sticky (1 bit, reset 0): set on a sampled low, cleared only by reset_n.
  - Adds output xerr_frames (8 bits, reset 0): saturating count of GS cycles with ≥1 sampled low.
- Undefined: these ports are absent, led_xerr is unused, and no synchroniser flops exist.

Test Plan:
- Reset release, enable=1, DC_ON_START=1 → shift_start with shift_dc=1, led_mode=1. Drive shift_done after 96 clocks → single 1-clock xlat with mode=1; mode=0 the next clock; blank stays high 4 clocks; gsclk starts.
- GS_BITS=4, no frame_req → RUN lasts 32 clocks with 16 gsclk rising edges; blank high 4 clocks; no xlat; frame_count goes 0,1,2 over three cycles.
- frame_req during RUN, shift_done 20 clocks later → exactly one xlat, at blank clock 1 of the next BLANK; pending cleared afterwards.
- Three frame_req pulses while busy=1 → exactly one extra shift_start, issued 1 clock after shift_done.
- enable=0 at RUN mid-point → gsclk completes all 16 edges, then blank=1 held indefinitely in IDLE. Assert reset_n=0 mid-DC_SHIFT → all outputs return to reset values within the same clock, asynchronously.
- LED_XERR_MONITOR_EN defined, led_xerr=0 during RUN gs_count 5..7 → xerr_sticky=1 and xerr_frames=1. led_xerr=0 only during BLANK → no change.

Source files
------------

// File: rtl/tlc_frame_scheduler_if.sv
// Shift request/acknowledge handshake between the frame scheduler (master)
// and the serial pixel shifter (slave).
interface tlc_frame_scheduler_if;
  logic shift_start;  // one-clock pulse: shifter begins loading the chain
  logic shift_dc;     // qualifies shift_start: 1 = DC data, 0 = GS data
  logic shift_done;   // one-clock pulse from shifter: last bit shifted

  modport master (
    output shift_start,
    output shift_dc,
    input  shift_done
  );

  modport slave (
    input  shift_start,
    input  shift_dc,
    output shift_done
  );
endinterface

// File: rtl/tlc_frame_scheduler.sv
// tlc_frame_scheduler: owns BLANK / XLAT / MODE / GSCLK timing for one LED
// driver chain and issues shift requests to the serial shifter. After reset
// it optionally uploads dot-correction data, then runs back-to-back GS PWM
// cycles separated by a blank window in which fresh GS data is latched.
//
// Optional feature macro: LED_XERR_MONITOR_EN
//   Adds a synchronised XERR monitor with outputs xerr_sticky / xerr_frames.
//   Without it led_xerr is ignored and no synchroniser flops are built.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | blanked, waiting for enable
// S_DC_SHIFT| MODE=1, DC data being shifted, waiting for shift_done
// S_DC_LATCH| MODE=1, single XLAT clock latching the DC register
// S_BLANK   | BLANK=1 window; frame_tick on entry, GS XLAT on clock 1
// S_RUN     | BLANK=0, GSCLK toggling for one full GS PWM cycle
module tlc_frame_scheduler #(
  parameter int GS_BITS      = 12,
  parameter int BLANK_CYCLES = 4,
  parameter bit DC_ON_START  = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         frame_req,
  tlc_frame_scheduler_if.master        shift_if,
  output logic                         led_mode,
  output logic                         led_blank,
  output logic                         led_xlat,
  output logic                         led_gsclk,
  input  logic                         led_xerr,
  output logic                         frame_tick,
  output logic [15:0]                  frame_count
`ifdef LED_XERR_MONITOR_EN
  ,
  output logic                         xerr_sticky,
  output logic [7:0]                   xerr_frames
`endif
);

  localparam int BW = $clog2(BLANK_CYCLES);
  localparam logic [BW-1:0]    BLANK_LOAD = BW'(BLANK_CYCLES - 1);
  localparam logic [BW-1:0]    BLANK_XLAT = BW'(BLANK_CYCLES - 2);
  localparam logic [GS_BITS:0] GS_LAST    = {1'b1, {GS_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DC_SHIFT,
    S_DC_LATCH,
    S_BLANK,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     blank_cnt_q, blank_cnt_d;
  logic [GS_BITS:0]  gs_count_q, gs_count_d;
  logic              gsclk_q, gsclk_d;
  logic              xlat_q, xlat_d;
  logic              pending_q, pending_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              shift_start_q, shift_start_d;
  logic              shift_dc_q, shift_dc_d;
  logic [15:0]       frame_count_q, frame_count_d;

  logic              shift_done;
  logic              enter_blank;
  logic              run_exit;
  logic              dc_start;
  logic              dc_phase;
  logic              gs_done;
  logic              gs_req;
  logic              gs_start;
  logic              busy_eff;

  assign shift_done = shift_if.shift_done;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Leaving IDLE for a DC upload waits until any GS shift
  // still in flight has finished, so the shifter never sees two requests.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          if (DC_ON_START) begin
            if (!busy_q) state_d = S_DC_SHIFT;
          end else begin
            state_d = S_BLANK;
          end
        end
      end
      S_DC_SHIFT: if (shift_done) state_d = S_DC_LATCH;
      S_DC_LATCH: state_d = S_BLANK;
      S_BLANK: begin
        if (blank_cnt_q == '0) state_d = enable ? S_RUN : S_IDLE;
      end
      S_RUN: if (gs_count_q == GS_LAST) state_d = S_BLANK;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: timers, GSCLK, handshake state, frame counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blank_cnt_q   <= '0;
      gs_count_q    <= '0;
      gsclk_q       <= 1'b0;
      xlat_q        <= 1'b0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
      req_q         <= 1'b0;
      shift_start_q <= 1'b0;
      shift_dc_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      blank_cnt_q   <= blank_cnt_d;
      gs_count_q    <= gs_count_d;
      gsclk_q       <= gsclk_d;
      xlat_q        <= xlat_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      req_q         <= req_d;
      shift_start_q <= shift_start_d;
      shift_dc_q    <= shift_dc_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Datapath next values. XLAT is computed one clock ahead so that a GS
  // shift_start can be held off whenever the next clock is an XLAT clock.
  always_comb begin
    enter_blank = (state_d == S_BLANK) && (state_q != S_BLANK);
    run_exit    = (state_q == S_RUN) && (state_d == S_BLANK);
    dc_start    = (state_q == S_IDLE) && (state_d == S_DC_SHIFT);

    // Blank window down-counter; index 0 is the entry clock.
    blank_cnt_d = blank_cnt_q;
    if (enter_blank) begin
      blank_cnt_d = BLANK_LOAD;
    end else if ((state_q == S_BLANK) && (blank_cnt_q != '0)) begin
      blank_cnt_d = blank_cnt_q - 1'b1;
    end

    // GSCLK toggles every clock in RUN; count rising edges. Forced low and
    // cleared on the clock that leaves RUN.
    gsclk_d    = 1'b0;
    gs_count_d = '0;
    if ((state_q == S_RUN) && (state_d == S_RUN)) begin
      gsclk_d    = ~gsclk_q;
      gs_count_d = gs_count_q + {{GS_BITS{1'b0}}, ~gsclk_q};
    end

    frame_count_d = frame_count_q;
    if (run_exit) frame_count_d = frame_count_q + 16'd1;

    // A finished GS shift marks data pending; a GS XLAT consumes it unless
    // another shift finishes on that same clock.
    gs_done   = shift_done && !shift_dc_q;
    pending_d = (pending_q && !(xlat_q && (state_q == S_BLANK))) || gs_done;

    xlat_d = (state_d == S_DC_LATCH) ||
             ((state_d == S_BLANK) && (blank_cnt_d == BLANK_XLAT) && pending_d);

    // GS requests are held in a single coalescing slot while the shifter is
    // busy, while a DC upload owns the shifter, or on an XLAT clock.
    busy_eff = busy_q && !shift_done;
    dc_phase = (state_q == S_DC_SHIFT) || (state_q == S_DC_LATCH) ||
               ((state_q == S_IDLE) && enable && DC_ON_START);
    gs_req   = frame_req || req_q;
    gs_start = gs_req && !busy_eff && !dc_phase && !xlat_d;
    req_d    = gs_req && !gs_start;

    shift_start_d = dc_start || gs_start;
    busy_d        = shift_start_d || busy_eff;

    shift_dc_d = shift_dc_q;
    if (dc_start) begin
      shift_dc_d = 1'b1;
    end else if (gs_start || shift_done) begin
      shift_dc_d = 1'b0;
    end
  end

  // Output decode; everything comes straight from flops so reset reaches
  // the pins asynchronously.
  always_comb begin
    led_blank            = (state_q != S_RUN);
    led_mode             = (state_q == S_DC_SHIFT) || (state_q == S_DC_LATCH);
    led_xlat             = xlat_q;
    led_gsclk            = gsclk_q;
    frame_tick           = (state_q == S_BLANK) && (blank_cnt_q == BLANK_LOAD);
    frame_count          = frame_count_q;
    shift_if.shift_start = shift_start_q;
    shift_if.shift_dc    = shift_dc_q;
  end

`ifdef LED_XERR_MONITOR_EN
  localparam logic [GS_BITS:0] XERR_MIN = (GS_BITS + 1)'(2);

  logic       xerr_meta_q, xerr_sync_q;
  logic       xerr_sticky_q, xerr_sticky_d;
  logic       xerr_seen_q, xerr_seen_d;
  logic [7:0] xerr_frames_q, xerr_frames_d;
  logic       xerr_hit;

  // Two-flop synchroniser for the asynchronous, active-low XERR pin.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xerr_meta_q <= 1'b1;
      xerr_sync_q <= 1'b1;
    end else begin
      xerr_meta_q <= led_xerr;
      xerr_sync_q <= xerr_meta_q;
    end
  end

  // Monitor registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xerr_sticky_q <= 1'b0;
      xerr_seen_q   <= 1'b0;
      xerr_frames_q <= '0;
    end else begin
      xerr_sticky_q <= xerr_sticky_d;
      xerr_seen_q   <= xerr_seen_d;
      xerr_frames_q <= xerr_frames_d;
    end
  end

  // XERR is only meaningful while the outputs are driven, so sample in RUN
  // after the first couple of GSCLK edges; count each affected GS cycle once.
  always_comb begin
    xerr_hit      = (state_q == S_RUN) && (gs_count_q >= XERR_MIN) && !xerr_sync_q;
    xerr_sticky_d = xerr_sticky_q || xerr_hit;
    xerr_seen_d   = xerr_seen_q || xerr_hit;
    xerr_frames_d = xerr_frames_q;
    if (run_exit) begin
      xerr_seen_d = 1'b0;
      if ((xerr_seen_q || xerr_hit) && (xerr_frames_q != 8'hFF)) begin
        xerr_frames_d = xerr_frames_q + 8'd1;
      end
    end
  end

  assign xerr_sticky = xerr_sticky_q;
  assign xerr_frames = xerr_frames_q;
`else
  logic unused_xerr;
  assign unused_xerr = led_xerr;
`endif

endmodule

// File: tb/tb_tlc_frame_scheduler.sv
// Directed bench for tlc_frame_scheduler with GS_BITS=4, BLANK_CYCLES=4.
module tb_tlc_frame_scheduler;
  localparam int GS_BITS      = 4;
  localparam int BLANK_CYCLES = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        frame_req;
  logic        led_mode, led_blank, led_xlat, led_gsclk, led_xerr;
  logic        frame_tick;
  logic [15:0] frame_count;
`ifdef LED_XERR_MONITOR_EN
  logic        xerr_sticky;
  logic [7:0]  xerr_frames;
`endif

  tlc_frame_scheduler_if shift_if ();

  tlc_frame_scheduler #(
    .GS_BITS(GS_BITS),
    .BLANK_CYCLES(BLANK_CYCLES),
    .DC_ON_START(1'b1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .frame_req(frame_req),
    .shift_if(shift_if),
    .led_mode(led_mode),
    .led_blank(led_blank),
    .led_xlat(led_xlat),
    .led_gsclk(led_gsclk),
    .led_xerr(led_xerr),
    .frame_tick(frame_tick),
    .frame_count(frame_count)
`ifdef LED_XERR_MONITOR_EN
    ,
    .xerr_sticky(xerr_sticky),
    .xerr_frames(xerr_frames)
`endif
  );

  always #5 clock = ~clock;

  // Event counters sampled on the falling edge, away from the active edge.
  int   n_xlat = 0, n_start = 0, n_rise = 0, n_tick = 0;
  int   xlat_pos = -1, blank_run = 0;
  logic gsclk_prev = 1'b0;

  always @(negedge clock) begin
    if (led_xlat === 1'b1) begin
      n_xlat   <= n_xlat + 1;
      xlat_pos <= blank_run;
    end
    if (shift_if.shift_start === 1'b1) n_start <= n_start + 1;
    if (frame_tick === 1'b1) n_tick <= n_tick + 1;
    if (led_gsclk === 1'b1 && gsclk_prev === 1'b0) n_rise <= n_rise + 1;
    gsclk_prev <= led_gsclk;
    blank_run  <= (led_blank === 1'b1) ? blank_run + 1 : 0;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_mis++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // From a blank clock, step until BLANK drops; blen counts blank clocks seen.
  task automatic to_run(output int blen);
    blen = 0;
    while (led_blank === 1'b1 && blen < 64) begin
      blen++;
      step(1);
    end
    if (led_blank !== 1'b0) timeout("to_run");
  endtask

  // From a RUN clock, step until BLANK rises; rlen counts RUN clocks seen.
  task automatic to_blank(output int rlen);
    rlen = 0;
    while (led_blank === 1'b0 && rlen < 400) begin
      rlen++;
      step(1);
    end
    if (led_blank !== 1'b1) timeout("to_blank");
  endtask

  int blen, rlen, s0, x0, r0, t0;

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    frame_req = 1'b0;
    led_xerr = 1'b1;
    shift_if.shift_done = 1'b0;
    step(3);

    // Reset state
    check("rst_blank", led_blank, 1);
    check("rst_mode", led_mode, 0);
    check("rst_xlat", led_xlat, 0);
    check("rst_gsclk", led_gsclk, 0);
    check("rst_start", shift_if.shift_start, 0);
    check("rst_dc", shift_if.shift_dc, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_count", frame_count, 0);

    // DC upload after reset release
    s0 = n_start;
    reset_n = 1'b1;
    enable = 1'b1;
    step(1);
    check("dc_start", shift_if.shift_start, 1);
    check("dc_flag", shift_if.shift_dc, 1);
    check("dc_mode", led_mode, 1);
    check("dc_blank", led_blank, 1);
    step(1);
    check("dc_start_pulse", shift_if.shift_start, 0);
    check("dc_flag_hold", shift_if.shift_dc, 1);
    step(94);
    shift_if.shift_done = 1'b1;
    step(1);
    shift_if.shift_done = 1'b0;
    check("dc_xlat", led_xlat, 1);
    check("dc_xlat_mode", led_mode, 1);
    step(1);
    check("dc_xlat_single", led_xlat, 0);
    check("dc_mode_off", led_mode, 0);
    check("dc_blank_b0", led_blank, 1);
    check("tick_first", frame_tick, 1);
    check("count_first", frame_count, 0);
    check("dc_start_count", n_start - s0, 1);
    x0 = n_xlat;
    step(1);
    check("tick_pulse", frame_tick, 0);
    to_run(blen);
    check("blank_len_dc", blen, 3);
    check("gsclk_r0", led_gsclk, 0);

    // Free-running GS cycles with no new data
    r0 = n_rise;
    to_blank(rlen);
    check("run_len_1", rlen, 32);
    check("rises_1", n_rise - r0, 16);
    check("tick_2", frame_tick, 1);
    check("count_1", frame_count, 1);
    to_run(blen);
    check("blank_len_2", blen, 4);
    r0 = n_rise;
    to_blank(rlen);
    check("run_len_2", rlen, 32);
    check("rises_2", n_rise - r0, 16);
    check("count_2", frame_count, 2);
    check("no_xlat_idle", n_xlat - x0, 0);

    // frame_req during RUN, shift_done 20 clocks later
    to_run(blen);
    step(3);
    s0 = n_start;
    frame_req = 1'b1;
    step(1);
    frame_req = 1'b0;
    check("gs_start", shift_if.shift_start, 1);
    check("gs_flag", shift_if.shift_dc, 0);
    step(19);
    shift_if.shift_done = 1'b1;
    step(1);
    shift_if.shift_done = 1'b0;
    to_blank(rlen);
    x0 = n_xlat;
    check("gs_b0_noxlat", led_xlat, 0);
    step(1);
    check("gs_b1_xlat", led_xlat, 1);
    check("gs_b1_blank", led_blank, 1);
    step(1);
    check("gs_b2_noxlat", led_xlat, 0);
    to_run(blen);
    to_blank(rlen);
    to_run(blen);
    check("gs_xlat_once", n_xlat - x0, 1);
    check("gs_start_once", n_start - s0, 1);

    // Three requests while busy coalesce into one extra shift
    s0 = n_start;
    frame_req = 1'b1;
    step(1);
    frame_req = 1'b0;
    check("co_first_start", shift_if.shift_start, 1);
    step(2);
    for (int i = 0; i < 3; i++) begin
      frame_req = 1'b1;
      step(1);
      frame_req = 1'b0;
      step(1);
    end
    step(1);
    check("co_held_busy", n_start - s0, 1);
    shift_if.shift_done = 1'b1;
    step(1);
    shift_if.shift_done = 1'b0;
    check("co_reissue", shift_if.shift_start, 1);
    check("co_reissue_gs", shift_if.shift_dc, 0);
    step(2);
    check("co_two_starts", n_start - s0, 2);
    step(2);
    shift_if.shift_done = 1'b1;
    step(1);
    shift_if.shift_done = 1'b0;
    step(3);
    check("co_no_third", n_start - s0, 2);
    to_blank(rlen);
    x0 = n_xlat;
`ifdef LED_XERR_MONITOR_EN
    led_xerr = 1'b0;
`endif
    step(3);
    led_xerr = 1'b1;
    check("co_xlat_once", n_xlat - x0, 1);
    check("co_xlat_pos", xlat_pos, 1);

    // enable dropped mid-RUN: cycle completes, then held blank in IDLE
    step(1);
    check("en_run", led_blank, 0);
    r0 = n_rise;
    t0 = n_tick;
`ifdef LED_XERR_MONITOR_EN
    check("xerr_blank_ignored", xerr_sticky, 0);
    step(9);
    led_xerr = 1'b0;
    step(6);
    led_xerr = 1'b1;
`else
    step(15);
`endif
    enable = 1'b0;
    to_blank(rlen);
    check("en_run_rest", rlen, 17);
    check("en_rises", n_rise - r0, 16);
    step(20);
    check("en_hold_blank", led_blank, 1);
    check("en_hold_gsclk", led_gsclk, 0);
    check("en_no_more_rises", n_rise - r0, 16);
    check("en_one_tick", n_tick - t0, 1);
`ifdef LED_XERR_MONITOR_EN
    check("xerr_sticky", xerr_sticky, 1);
    check("xerr_frames", xerr_frames, 1);
`endif

    // Asynchronous reset in the middle of a DC upload
    enable = 1'b1;
    step(1);
    check("dc2_mode", led_mode, 1);
    check("dc2_start", shift_if.shift_start, 1);
    step(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_mode", led_mode, 0);
    check("arst_dc", shift_if.shift_dc, 0);
    check("arst_blank", led_blank, 1);
    check("arst_xlat", led_xlat, 0);
    check("arst_start", shift_if.shift_start, 0);
    check("arst_count", frame_count, 0);
`ifdef LED_XERR_MONITOR_EN
    check("arst_sticky", xerr_sticky, 0);
`endif
    step(2);
    reset_n = 1'b1;
    enable = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
